// File: rtl/dmem_responder.sv
// Data-memory responder for the multicycle MIPS core: byte-writable RAM plus an
// I/O page at 0x3F0-0x3FF holding a GPIO register and a down-counting timer.
module dmem_responder #(
  parameter int RAM_WORDS = 1008,
  parameter int GPIO_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:2]       dmem_addr,
  input  logic [31:0]       dmem_din,
  input  logic [3:0]        dmem_be,
  input  logic              dmem_wren,
  output logic [31:0]       dmem_dout,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam logic [9:0]  A_GPIO   = 10'h3F0;
  localparam logic [9:0]  A_CTRL   = 10'h3F1;
  localparam logic [9:0]  A_LOAD   = 10'h3F2;
  localparam logic [9:0]  A_COUNT  = 10'h3F3;
  localparam logic [9:0]  A_STATUS = 10'h3F4;
  localparam logic [10:0] RAM_TOP  = 11'(RAM_WORDS);

  logic [31:0]       ram [RAM_WORDS];
  logic [GPIO_W-1:0] gpio_q, gpio_n;
  logic              en_q, ar_q, ie_q, en_n, ar_n, ie_n;
  logic [31:0]       load_q, load_n, count_q, count_n;
  logic              expired_q, expired_n;
  logic [31:0]       rd_data, be_mask, load_merged;
  logic              is_ram, wr_gpio, wr_ctrl, wr_load, wr_status, terminal;

  assign is_ram    = {1'b0, dmem_addr} < RAM_TOP;
  assign be_mask   = {{8{dmem_be[3]}}, {8{dmem_be[2]}}, {8{dmem_be[1]}}, {8{dmem_be[0]}}};
  assign wr_gpio   = dmem_wren && (dmem_addr == A_GPIO);
  assign wr_ctrl   = dmem_wren && (dmem_addr == A_CTRL) && dmem_be[0];
  // An all-zero byte enable is treated as no write at all, so COUNT is not reloaded.
  assign wr_load   = dmem_wren && (dmem_addr == A_LOAD) && (dmem_be != 4'b0000);
  assign wr_status = dmem_wren && (dmem_addr == A_STATUS) && dmem_be[0] && dmem_din[0];
  assign load_merged = (load_q & ~be_mask) | (dmem_din & be_mask);
  assign terminal  = en_q && (count_q == 32'd0);

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (dmem_wren && is_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_be[i]) ram[dmem_addr][i*8 +: 8] <= dmem_din[i*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (is_ram) begin
      rd_data = ram[dmem_addr];
    end else begin
      case (dmem_addr)
        A_GPIO:   rd_data[GPIO_W-1:0] = gpio_q;
        A_CTRL:   rd_data[2:0] = {ie_q, ar_q, en_q};
        A_LOAD:   rd_data = load_q;
        A_COUNT:  rd_data = count_q;
        A_STATUS: rd_data[0] = expired_q;
        default:  rd_data = '0;
      endcase
    end
  end

  always_comb begin
    gpio_n = gpio_q;
    if (wr_gpio) begin
      for (int i = 0; i < GPIO_W; i++) begin
        if (dmem_be[i/8]) gpio_n[i] = dmem_din[i];
      end
    end
  end

  // Timer next state; core writes are applied last so they win over the countdown.
  always_comb begin
    count_n   = count_q;
    load_n    = load_q;
    en_n      = en_q;
    ar_n      = ar_q;
    ie_n      = ie_q;
    expired_n = expired_q;
    if (en_q) begin
      if (count_q != 32'd0)  count_n = count_q - 32'd1;
      else if (ar_q)         count_n = load_q;
      else                   en_n = 1'b0;
    end
    if (terminal)            expired_n = 1'b1;
    else if (wr_status)      expired_n = 1'b0;
    if (wr_ctrl)             {ie_n, ar_n, en_n} = dmem_din[2:0];
    if (wr_load) begin
      load_n  = load_merged;
      count_n = load_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_dout <= '0;
      gpio_q    <= '0;
      en_q      <= 1'b0;
      ar_q      <= 1'b0;
      ie_q      <= 1'b0;
      load_q    <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      dmem_dout <= rd_data;
      gpio_q    <= gpio_n;
      en_q      <= en_n;
      ar_q      <= ar_n;
      ie_q      <= ie_n;
      load_q    <= load_n;
      count_q   <= count_n;
      expired_q <= expired_n;
    end
  end

  assign gpio_out  = gpio_q;
  assign timer_irq = expired_q & ie_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a transaction-level memory/timer model.
module tb_dmem_responder;
  localparam int RAM_WORDS = 1008;
  localparam int GPIO_W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [11:2]       dmem_addr;
  logic [31:0]       dmem_din;
  logic [3:0]        dmem_be;
  logic              dmem_wren;
  logic [31:0]       dmem_dout;
  logic [GPIO_W-1:0] gpio_out;
  logic              timer_irq;

  dmem_responder #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W)) dut (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_be(dmem_be), .dmem_wren(dmem_wren), .dmem_dout(dmem_dout),
    .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  logic [31:0] m_ram [0:1023];
  logic [31:0] m_gpio, m_load, m_count;
  logic        m_en, m_ar, m_ie, m_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a < RAM_WORDS) return m_ram[a];
    case (a)
      'h3F0: return m_gpio;
      'h3F1: return {29'd0, m_ie, m_ar, m_en};
      'h3F2: return m_load;
      'h3F3: return m_count;
      'h3F4: return {31'd0, m_exp};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_gpio = 0; m_load = 0; m_count = 0;
    m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
    exp_q.delete();
  endtask

  // One clock edge of the memory map, described from the register rules.
  task automatic model_step(input int a, input logic [31:0] d, input logic [3:0] be,
                            input logic we);
    logic hit_zero;
    exp_q.push_back(m_read(a));
    hit_zero = m_en && (m_count == 0);
    if (m_en) begin
      if (m_count > 0) m_count = m_count - 1;
      else if (m_ar)   m_count = m_load;
      else             m_en = 0;
    end
    m_exp = hit_zero | (m_exp & !(we && a == 'h3F4 && be[0] && d[0]));
    if (we) begin
      if (a < RAM_WORDS) m_ram[a] = merge(m_ram[a], d, be);
      else if (a == 'h3F0) m_gpio = merge(m_gpio, d, be) & 32'h0000FFFF;
      else if (a == 'h3F1 && be[0]) {m_ie, m_ar, m_en} = d[2:0];
      else if (a == 'h3F2 && be != 0) begin
        m_load  = merge(m_load, d, be);
        m_count = m_load;
      end
    end
  endtask

  task automatic cyc(input int a, input logic [31:0] d, input logic [3:0] be,
                     input logic we, input logic chk_dout);
    logic [31:0] want;
    dmem_addr = 10'(a); dmem_din = d; dmem_be = be; dmem_wren = we;
    @(posedge clk);
    model_step(a, d, be, we);
    #1;
    want = exp_q.pop_front();
    if (chk_dout) check("dout", dmem_dout, want);
    check("gpio", 32'(gpio_out), m_gpio);
    check("irq", {31'd0, timer_irq}, {31'd0, m_exp & m_ie});
  endtask

  task automatic rd(input int a);
    cyc(a, $urandom, 4'hF, 1'b0, 1'b1);
  endtask

  // Reset asserted between edges: outputs must drop before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_dout", dmem_dout, 32'd0);
    check("rst_gpio", 32'(gpio_out), 32'd0);
    check("rst_irq", {31'd0, timer_irq}, 32'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;
  endtask

  int seq [6] = '{2, 1, 0, 2, 1, 0};
  int a;

  initial begin
    rst = 1'b1; dmem_addr = '0; dmem_din = '0; dmem_be = '0; dmem_wren = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", dmem_dout, 32'd0);
    check("reset_gpio", 32'(gpio_out), 32'd0);
    check("reset_irq", {31'd0, timer_irq}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Fill RAM so every later read has a known value.
    for (int i = 0; i < RAM_WORDS; i++) cyc(i, $urandom, 4'hF, 1'b1, 1'b0);

    // Byte-enable merge
    cyc('h010, 32'hAABBCCDD, 4'b1111, 1'b1, 1'b1);
    cyc('h010, 32'h11223344, 4'b0101, 1'b1, 1'b1);
    rd('h010);
    check("ram_be", dmem_dout, 32'hAA22CC44);

    // Read-before-write at the top RAM word, ignored writes in the I/O page
    cyc('h3EF, 32'h7, 4'hF, 1'b1, 1'b1);
    cyc('h3EF, 32'h5, 4'hF, 1'b1, 1'b1);
    check("rbw_old", dmem_dout, 32'h7);
    rd('h3EF);
    check("rbw_new", dmem_dout, 32'h5);
    cyc('h3F3, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    cyc('h3FA, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
    rd('h3F3);
    check("count_ro", dmem_dout, 32'd0);
    rd('h3FA);
    check("hole_zero", dmem_dout, 32'd0);

    // GPIO
    cyc('h3F0, 32'hFFFF1234, 4'b0011, 1'b1, 1'b1);
    check("gpio_val", 32'(gpio_out), 32'h1234);
    rd('h3F0);
    check("gpio_rd", dmem_dout, 32'h00001234);

    // One-shot: LOAD=3, CTRL=en|irq_en; terminal at the 4th edge
    cyc('h3F2, 32'd3, 4'hF, 1'b1, 1'b1);
    cyc('h3F1, 32'b101, 4'b0001, 1'b1, 1'b1);
    repeat (3) rd('h3F4);
    check("oneshot_early", {31'd0, timer_irq}, 32'd0);
    rd('h3F4);
    check("oneshot_irq", {31'd0, timer_irq}, 32'd1);
    rd('h3F1);
    check("oneshot_ctrl", dmem_dout, 32'b100);
    rd('h3F3);
    check("oneshot_count", dmem_dout, 32'd0);
    cyc('h3F4, 32'd1, 4'b0001, 1'b1, 1'b1);
    check("w1c_irq", {31'd0, timer_irq}, 32'd0);

    // Auto-reload: LOAD=2, CTRL=0b111, COUNT reads 2,1,0,2,1,0
    cyc('h3F2, 32'd2, 4'hF, 1'b1, 1'b1);
    cyc('h3F1, 32'b111, 4'b0001, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      rd('h3F3);
      check("reload_seq", dmem_dout, 32'(seq[k]));
    end
    cyc('h3F4, 32'd1, 4'b0001, 1'b1, 1'b1);
    check("reload_clr", {31'd0, timer_irq}, 32'd0);
    rd('h3F4);
    cyc('h3F4, 32'd1, 4'b0001, 1'b1, 1'b1);
    check("w1c_vs_set", {31'd0, timer_irq}, 32'd1);

    // Reset during a countdown
    cyc('h3F2, 32'd100, 4'hF, 1'b1, 1'b1);
    cyc('h3F1, 32'b101, 4'b0001, 1'b1, 1'b1);
    repeat (5) rd('h3F3);
    async_reset();
    rd('h3F3);
    rd('h3F3);
    check("count_after_rst", dmem_dout, 32'd0);

    // Random traffic, with the occasional asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      case ($urandom_range(0, 3))
        0: a = 'h3F0 + $urandom_range(0, 15);
        1: a = $urandom_range(0, 15);
        2: a = 'h3E0 + $urandom_range(0, 15);
        default: a = 'h3F1 + $urandom_range(0, 3);
      endcase
      cyc(a, (a == 'h3F2) ? 32'($urandom_range(0, 6)) : $urandom,
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
